// File: rtl/gticc_rxalign.sv
// gticc_rxalign: 2-byte GT RX comma aligner with HUNT/VERIFY/LOCKED lock FSM, aligned registered output and saturating error count
module gticc_rxalign #(
  parameter logic [7:0] COMMA   = 8'hBC,
  parameter int         NVERIFY = 4,
  parameter int         NLOSS   = 8,
  parameter int         ERRW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            gtresetdone,
  input  logic [15:0]     rxdata,
  input  logic [1:0]      rxcharisk,
  input  logic [1:0]      rxdisperr,
  input  logic [1:0]      rxnotintable,
  input  logic            errclr,
  output logic [15:0]     dout,
  output logic [1:0]      doutk,
  output logic            dvalid,
  output logic            linkup,
  output logic            realign,
  output logic            offset,
  output logic [ERRW-1:0] errcnt,
  output logic [1:0]      state
);
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;
  localparam int GW = $clog2(NVERIFY + 1);
  localparam int BW = $clog2(NLOSS + 1);
  state_t          r_state, w_state;
  logic            r_offset, w_offset, r_realign, w_realign, r_dvalid, r_prevk;
  logic [GW-1:0]   r_goodcnt, w_goodcnt;
  logic [BW-1:0]   r_badcnt, w_badcnt;
  logic [ERRW-1:0] r_errcnt;
  logic [7:0]      r_prev;
  logic [15:0]     r_dout, w_adata;
  logic [1:0]      r_doutk, w_ak;
  logic            w_c0, w_c1, w_comma, w_lane, w_bad, w_miss, w_locked, w_err;
  assign w_c0     = rxcharisk[0] && rxdata[7:0] == COMMA;
  assign w_c1     = rxcharisk[1] && rxdata[15:8] == COMMA;
  assign w_comma  = gtresetdone && (w_c0 || w_c1);
  assign w_lane   = !w_c0;
  assign w_bad    = |{rxdisperr, rxnotintable};
  assign w_miss   = w_bad || (w_comma && w_lane != r_offset);
  assign w_locked = r_state == LOCKED;
  assign w_err    = gtresetdone && w_locked && w_bad;
  assign w_adata  = r_offset ? {rxdata[7:0], r_prev} : rxdata;
  assign w_ak     = r_offset ? {rxcharisk[0], r_prevk} : rxcharisk;
  always_comb begin
    w_state   = r_state;
    w_offset  = r_offset;
    w_goodcnt = r_goodcnt;
    w_badcnt  = r_badcnt;
    w_realign = 1'b0;
    if (!gtresetdone) w_state = HUNT;
    else if (r_state == HUNT) begin
      if (w_comma && !w_bad) begin
        w_state   = VERIFY;
        w_offset  = w_lane;
        w_goodcnt = GW'(1);
      end
    end else if (r_state == VERIFY) begin
      if (w_miss) w_state = HUNT;
      else if (w_comma) begin
        w_goodcnt = r_goodcnt + GW'(1);
        if (w_goodcnt == GW'(NVERIFY)) begin
          w_state  = LOCKED;
          w_badcnt = '0;
        end
      end
    end else if (r_state == LOCKED) begin
      w_badcnt = w_miss ? r_badcnt + BW'(1) : '0;
      if (w_miss && w_badcnt == BW'(NLOSS)) begin
        w_state   = HUNT;
        w_realign = 1'b1;
      end
    end else w_state = HUNT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= HUNT;
      r_offset  <= 1'b0;
      r_goodcnt <= '0;
      r_badcnt  <= '0;
      r_realign <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_offset  <= w_offset;
      r_goodcnt <= w_goodcnt;
      r_badcnt  <= w_badcnt;
      r_realign <= w_realign;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev   <= '0;
      r_prevk  <= 1'b0;
      r_dout   <= '0;
      r_doutk  <= '0;
      r_dvalid <= 1'b0;
      r_errcnt <= '0;
    end else begin
      r_prev   <= rxdata[15:8];
      r_prevk  <= rxcharisk[1];
      r_dout   <= w_locked ? w_adata : '0;
      r_doutk  <= w_locked ? w_ak : '0;
      r_dvalid <= w_locked;
      if (errclr) r_errcnt <= ERRW'(w_err);
      else if (w_err && !(&r_errcnt)) r_errcnt <= r_errcnt + ERRW'(1);
    end
  end
  assign dout    = r_dout;
  assign doutk   = r_doutk;
  assign dvalid  = r_dvalid;
  assign linkup  = w_locked;
  assign realign = r_realign;
  assign offset  = r_offset;
  assign errcnt  = r_errcnt;
  assign state   = r_state;
endmodule

// File: tb/tb_gticc_rxalign.sv
// tb_gticc_rxalign: randomized and directed checks of gticc_rxalign against a behavioural model
module tb_gticc_rxalign;
  logic clk = 1'b0;
  logic reset, gtresetdone, errclr;
  logic [15:0] rxdata;
  logic [1:0] rxcharisk, rxdisperr, rxnotintable;
  logic [15:0] dout;
  logic [1:0] doutk;
  logic dvalid, linkup, realign, offset;
  logic [3:0] errcnt;
  logic [1:0] state;
  int total = 0, bad = 0, nreal = 0;
  int m_st, m_off, m_g, m_b, m_err, m_real;
  logic [15:0] m_pd, m_dout;
  logic [1:0] m_pk, m_doutk;
  logic m_dv;
  always #5 clk = ~clk;
  gticc_rxalign #(.ERRW(4)) dut (
    .clk(clk), .reset(reset), .gtresetdone(gtresetdone), .rxdata(rxdata),
    .rxcharisk(rxcharisk), .rxdisperr(rxdisperr), .rxnotintable(rxnotintable),
    .errclr(errclr), .dout(dout), .doutk(doutk), .dvalid(dvalid), .linkup(linkup),
    .realign(realign), .offset(offset), .errcnt(errcnt), .state(state)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model();
    logic c0, c1, has, lane, bd, miss;
    if (reset) begin
      m_st = 0; m_off = 0; m_g = 0; m_b = 0; m_err = 0; m_real = 0;
      m_pd = '0; m_pk = '0; m_dout = '0; m_doutk = '0; m_dv = 1'b0;
      return;
    end
    m_dv = m_st == 2;
    m_dout = !m_dv ? 16'h0 : m_off != 0 ? {rxdata[7:0], m_pd[15:8]} : rxdata;
    m_doutk = !m_dv ? 2'b0 : m_off != 0 ? {rxcharisk[0], m_pk[1]} : rxcharisk;
    bd = |{rxdisperr, rxnotintable};
    c0 = rxcharisk[0] && rxdata[7:0] == 8'hBC;
    c1 = rxcharisk[1] && rxdata[15:8] == 8'hBC;
    has = gtresetdone && (c0 || c1);
    lane = !c0;
    miss = bd || (has && int'(lane) != m_off);
    if (errclr) m_err = (gtresetdone && m_dv && bd) ? 1 : 0;
    else if (gtresetdone && m_dv && bd && m_err < 15) m_err++;
    m_real = 0;
    if (!gtresetdone) m_st = 0;
    else if (m_st == 0) begin
      if (has && !bd) begin m_st = 1; m_off = int'(lane); m_g = 1; end
    end else if (m_st == 1) begin
      if (miss) m_st = 0;
      else if (has) begin
        m_g++;
        if (m_g == 4) begin m_st = 2; m_b = 0; end
      end
    end else begin
      if (miss) begin
        m_b++;
        if (m_b == 8) begin m_st = 0; m_real = 1; end
      end else m_b = 0;
    end
    m_pd = rxdata;
    m_pk = rxcharisk;
  endtask
  task automatic step(input logic [15:0] d, input logic [1:0] k, input logic [1:0] de,
                      input logic [1:0] ni, input logic gd, input logic ec, input logic rs);
    rxdata = d; rxcharisk = k; rxdisperr = de; rxnotintable = ni;
    gtresetdone = gd; errclr = ec; reset = rs;
    @(posedge clk);
    model();
    #1;
    chk("state", 32'(state), 32'(m_st));
    chk("offset", 32'(offset), 32'(m_off));
    chk("linkup", 32'(linkup), 32'(m_st == 2));
    chk("realign", 32'(realign), 32'(m_real));
    chk("errcnt", 32'(errcnt), 32'(m_err));
    chk("dvalid", 32'(dvalid), 32'(m_dv));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("doutk", 32'(doutk), 32'(m_doutk));
    if (realign) nreal++;
  endtask
  task automatic rst();
    step(16'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic lock0();
    repeat (4) step(16'h50BC, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic badw();
    step(16'h1234, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic goodw();
    step(16'h1234, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask
  initial begin
    int r, burst, pl;
    logic [15:0] d;
    logic [1:0] k, de, ni;
    rst();
    chk("rst_state", 32'(state), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_errcnt", 32'(errcnt), 0);
    lock0();
    chk("l0_state", 32'(state), 2);
    chk("l0_linkup", 32'(linkup), 1);
    step(16'h50BC, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("l0_dvalid", 32'(dvalid), 1);
    chk("l0_dout", 32'(dout), 32'h50BC);
    rst();
    repeat (4) step(16'hBC50, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("l1_offset", 32'(offset), 1);
    step(16'hBC11, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    step(16'h2233, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("l1_dout", 32'(dout), 32'h33BC);
    chk("l1_doutk", 32'(doutk), 1);
    rst();
    lock0();
    nreal = 0;
    repeat (8) badw();
    chk("loss_state", 32'(state), 0);
    chk("loss_errcnt", 32'(errcnt), 8);
    goodw();
    chk("loss_dvalid", 32'(dvalid), 0);
    goodw();
    chk("loss_pulses", 32'(nreal), 1);
    rst();
    lock0();
    repeat (7) badw();
    goodw();
    repeat (7) badw();
    chk("bclr_state", 32'(state), 2);
    chk("bclr_errcnt", 32'(errcnt), 14);
    rst();
    repeat (2) step(16'h50BC, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    step(16'hBC50, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("vab_hunt", 32'(state), 0);
    step(16'hBC50, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("vab_verify", 32'(state), 1);
    chk("vab_offset", 32'(offset), 1);
    rst();
    lock0();
    repeat (20) begin badw(); goodw(); end
    chk("sat_errcnt", 32'(errcnt), 15);
    chk("sat_state", 32'(state), 2);
    step(16'h1234, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("clr_errcnt", 32'(errcnt), 1);
    step(16'h50BC, 2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
    chk("mrst_state", 32'(state), 0);
    chk("mrst_errcnt", 32'(errcnt), 0);
    chk("mrst_dvalid", 32'(dvalid), 0);
    lock0();
    step(16'h1234, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("gtd_state", 32'(state), 0);
    chk("gtd_realign", 32'(realign), 0);
    chk("gtd_errcnt", 32'(errcnt), 0);
    burst = 0;
    pl = 0;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      d = 16'($urandom);
      k = 2'b00;
      de = 2'b00;
      ni = 2'b00;
      if ($urandom_range(0, 49) == 0) pl = 1 - pl;
      if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(6, 10);
      if (burst > 0) begin
        de = 2'($urandom_range(1, 3));
        burst--;
      end else if (r < 50) begin
        if ((r < 45) == (pl == 0)) begin d[7:0] = 8'hBC; k = 2'b01; end
        else begin d[15:8] = 8'hBC; k = 2'b10; end
      end else if (r < 80) k = 2'b00;
      else if (r < 90) de = 2'($urandom_range(1, 3));
      else begin
        if ($urandom_range(0, 1) == 1) d[7:0] = 8'hBC;
        if ($urandom_range(0, 1) == 1) d[15:8] = 8'hBC;
        k = 2'($urandom);
        de = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
        ni = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
      end
      step(d, k, de, ni, $urandom_range(0, 199) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 499) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
